// File: rtl/dm_access_ctrl_if.sv
// Data-memory access bundle: request/response channel from the MEM stage
// plus the word-addressed memory pins. The master side is the requester
// together with the memory; the slave side is the access controller.
interface dm_access_ctrl_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqData;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespData;
    logic        RespErr;
    logic [31:0] MemAddr;
    logic [31:0] MemDataIn;
    logic [31:0] MemDataOut;
    logic        MemWriteEnable;
    logic        MemReadEnable;

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqData,
        output RespReady, MemDataOut,
        input  ReqReady, RespValid, RespData, RespErr,
        input  MemAddr, MemDataIn, MemWriteEnable, MemReadEnable
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqData,
        input  RespReady, MemDataOut,
        output ReqReady, RespValid, RespData, RespErr,
        output MemAddr, MemDataIn, MemWriteEnable, MemReadEnable
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: one outstanding load/store, sub-word
// stores by read-modify-write, bad accesses answered without a bus cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ReqReady high, waiting for a request
// S_RD     | load read cycle; data captured and extended at next edge
// S_RMW_RD | sub-word store read cycle; lane merged at next edge
// S_WR     | single write cycle with full or merged word
// S_RESP   | RespValid held until RespReady
module dm_access_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_WIDTH   = 10
) (
    input  logic           Clk,
    input  logic           Reset,
    dm_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_data_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_din_q;
    logic        mem_we_q;
    logic        mem_re_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        unsigned_q;
    logic [15:0] st_data_q;

    logic        req_err_d;
    logic [7:0]  rd_byte_d;
    logic [15:0] rd_half_d;
    logic [31:0] load_d;
    logic [31:0] merged_d;

    assign bus.ReqReady       = req_ready_q;
    assign bus.RespValid      = resp_valid_q;
    assign bus.RespErr        = resp_err_q;
    assign bus.RespData       = resp_data_q;
    assign bus.MemAddr        = mem_addr_q;
    assign bus.MemDataIn      = mem_din_q;
    assign bus.MemWriteEnable = mem_we_q;
    assign bus.MemReadEnable  = mem_re_q;

    // Reject illegal size, misalignment and word indices beyond the memory.
    always_comb begin
        req_err_d = 1'b0;
        case (bus.ReqSize)
            2'b01:   req_err_d = bus.ReqAddr[0];
            2'b10:   req_err_d = |bus.ReqAddr[1:0];
            2'b11:   req_err_d = 1'b1;
            default: req_err_d = 1'b0;
        endcase
        if ({2'b00, bus.ReqAddr[31:2]} >= 32'(DEPTH_WORDS)) begin
            req_err_d = 1'b1;
        end
    end

    // Pick the addressed lane of the read word and extend it for loads.
    always_comb begin
        rd_byte_d = bus.MemDataOut[7:0];
        case (lane_q)
            2'd1:    rd_byte_d = bus.MemDataOut[15:8];
            2'd2:    rd_byte_d = bus.MemDataOut[23:16];
            2'd3:    rd_byte_d = bus.MemDataOut[31:24];
            default: rd_byte_d = bus.MemDataOut[7:0];
        endcase
        rd_half_d = lane_q[1] ? bus.MemDataOut[31:16] : bus.MemDataOut[15:0];
        case (size_q)
            2'b00:   load_d = unsigned_q ? {24'd0, rd_byte_d}
                                         : {{24{rd_byte_d[7]}}, rd_byte_d};
            2'b01:   load_d = unsigned_q ? {16'd0, rd_half_d}
                                         : {{16{rd_half_d[15]}}, rd_half_d};
            default: load_d = bus.MemDataOut;
        endcase
    end

    // Overlay the store byte/half onto the read word; other lanes untouched.
    always_comb begin
        merged_d = bus.MemDataOut;
        if (size_q == 2'b00) begin
            case (lane_q)
                2'd1:    merged_d[15:8]  = st_data_q[7:0];
                2'd2:    merged_d[23:16] = st_data_q[7:0];
                2'd3:    merged_d[31:24] = st_data_q[7:0];
                default: merged_d[7:0]   = st_data_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged_d[31:16] = st_data_q;
        end else begin
            merged_d[15:0] = st_data_q;
        end
    end

    // Sequencer with registered bus and response outputs; reset kills any
    // write strobe immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'd0;
            mem_addr_q   <= 32'd0;
            mem_din_q    <= 32'd0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            st_data_q    <= 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.ReqValid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        resp_data_q <= 32'd0;
                        size_q      <= bus.ReqSize;
                        lane_q      <= bus.ReqAddr[1:0];
                        unsigned_q  <= bus.ReqUnsigned;
                        st_data_q   <= bus.ReqData[15:0];
                        if (req_err_d) begin
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            resp_err_q <= 1'b0;
                            mem_addr_q <= {{(32-IDX_WIDTH){1'b0}},
                                           bus.ReqAddr[IDX_WIDTH+1:2]};
                            if (!bus.ReqWrite) begin
                                mem_re_q <= 1'b1;
                                state_q  <= S_RD;
                            end else if (bus.ReqSize == 2'b10) begin
                                mem_din_q <= bus.ReqData;
                                mem_we_q  <= 1'b1;
                                state_q   <= S_WR;
                            end else begin
                                mem_re_q <= 1'b1;
                                state_q  <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    mem_re_q     <= 1'b0;
                    resp_data_q  <= load_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RMW_RD: begin
                    mem_re_q  <= 1'b0;
                    mem_din_q <= merged_d;
                    mem_we_q  <= 1'b1;
                    state_q   <= S_WR;
                end
                S_WR: begin
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.RespReady) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    mem_re_q     <= 1'b0;
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: word memory model on the pins, byte-array
// reference model for expected load data, errors, latency and memory image.
module tb_dm_access_ctrl;

    logic Clk = 1'b0;
    logic Reset = 1'b0;

    dm_access_ctrl_if bus ();

    dm_access_ctrl #(.DEPTH_WORDS(1024), .IDX_WIDTH(10)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [0:1023];
    logic [7:0]  ref_bytes [0:4095];

    int n_cmp  = 0;
    int n_fail = 0;

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    bit          both_seen = 1'b0;
    logic [31:0] last_addr = 32'd0;

    // memory model: read data on negedge while read-enabled, write on posedge
    always @(negedge Clk) begin
        if (bus.MemReadEnable) bus.MemDataOut <= mem[bus.MemAddr[9:0]];
    end
    always @(posedge Clk) begin
        if (bus.MemWriteEnable) mem[bus.MemAddr[9:0]] <= bus.MemDataIn;
    end

    // bus activity monitor
    always @(negedge Clk) begin
        if (bus.MemReadEnable && bus.MemWriteEnable) both_seen = 1'b1;
        if (bus.MemReadEnable) rd_cnt = rd_cnt + 1;
        if (bus.MemWriteEnable) wr_cnt = wr_cnt + 1;
        if (bus.MemReadEnable || bus.MemWriteEnable) last_addr = bus.MemAddr;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_word(input int idx);
        return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
    endfunction

    function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        if (addr % (32'd1 << size) != 0) return 1'b1;
        if ((addr / 4) >= 1024) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input bit uns,
                                             input logic [31:0] addr);
        longint unsigned v = 0;
        int n = 1 << size;
        int a = int'(addr);
        for (int i = 0; i < n; i++) v = v + (longint'(ref_bytes[a+i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v - (64'd1 << (8*n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] data);
        int n = 1 << size;
        int a = int'(addr);
        for (int i = 0; i < n; i++) ref_bytes[a+i] = 8'(data >> (8*i));
    endtask

    function automatic int exp_lat(input bit wr, input logic [1:0] size, input bit err);
        if (err) return 1;
        if (wr && size != 2'd2) return 3;
        return 2;
    endfunction

    task automatic set_word(input int idx, input logic [31:0] w);
        mem[idx] = w;
        for (int i = 0; i < 4; i++) ref_bytes[4*idx+i] = 8'(w >> (8*i));
    endtask

    // ---------------- transaction driver ----------------
    task automatic issue(input bit wr, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] data,
                         input bit ready_early,
                         output logic [31:0] rdata, output logic rerr, output int lat,
                         output int nrd, output int nwr, output logic [31:0] maddr,
                         output bit idle_after);
        int rd0, wr0;
        bit ok;
        @(negedge Clk);
        bus.ReqValid    = 1'b1;
        bus.ReqWrite    = wr;
        bus.ReqSize     = size;
        bus.ReqUnsigned = uns;
        bus.ReqAddr     = addr;
        bus.ReqData     = data;
        bus.RespReady   = ready_early;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ReqReady) begin ok = 1'b1; break; end
            @(negedge Clk);
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: ReqReady=%0b required 1", bus.ReqReady);
        end
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge Clk); #1;
        bus.ReqValid = 1'b0;
        lat = 1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.RespValid) begin ok = 1'b1; break; end
            @(posedge Clk); #1;
            lat++;
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL resp_timeout: RespValid=%0b required 1", bus.RespValid);
        end
        rdata = bus.RespData;
        rerr  = bus.RespErr;
        nrd   = rd_cnt - rd0;
        nwr   = wr_cnt - wr0;
        maddr = last_addr;
        bus.RespReady = 1'b1;
        @(posedge Clk); #1;
        idle_after = bus.ReqReady && !bus.RespValid;
        bus.RespReady = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 Reset = 1'b1;
        @(posedge Clk); @(negedge Clk);
        n_cmp++;
        if ({bus.ReqReady, bus.RespValid, bus.RespErr, bus.MemWriteEnable, bus.MemReadEnable} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy/rv/err/we/re=%b required 10000",
                     {bus.ReqReady, bus.RespValid, bus.RespErr, bus.MemWriteEnable, bus.MemReadEnable});
        end
        n_cmp++;
        if (bus.RespData !== 32'd0) begin
            n_fail++; $display("FAIL reset_respdata: got %h required 0", bus.RespData);
        end
        n_cmp++;
        if ({bus.MemAddr, bus.MemDataIn} !== 64'd0) begin
            n_fail++; $display("FAIL reset_membus: addr %h din %h required 0", bus.MemAddr, bus.MemDataIn);
        end
        Reset = 1'b0;
    endtask

    task automatic test_sw_lw();
        logic [31:0] d, ma; logic e; int lat, nrd, nwr; bit ia;
        issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h0000_0031, 1'b0, d, e, lat, nrd, nwr, ma, ia);
        ref_store(2'd2, 32'h30, 32'h0000_0031);
        n_cmp++;
        if (e !== 1'b0 || lat != 2 || nwr != 1 || nrd != 0) begin
            n_fail++; $display("FAIL sw_timing: err %0b lat %0d wr %0d rd %0d required 0 2 1 0", e, lat, nwr, nrd);
        end
        n_cmp++;
        if (ma !== 32'h30 >> 2) begin
            n_fail++; $display("FAIL sw_addr: MemAddr %0d required %0d", ma, 32'h30 >> 2);
        end
        n_cmp++;
        if (mem[12] !== ref_word(12)) begin
            n_fail++; $display("FAIL sw_mem: word %h required %h", mem[12], ref_word(12));
        end
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b0, d, e, lat, nrd, nwr, ma, ia);
        n_cmp++;
        if (d !== ref_load(2'd2, 1'b0, 32'h30) || e !== 1'b0) begin
            n_fail++; $display("FAIL lw_data: data %h err %0b required %h 0", d, e, ref_load(2'd2, 1'b0, 32'h30));
        end
        n_cmp++;
        if (lat != 2 || nrd != 1 || nwr != 0 || ma !== 32'd12) begin
            n_fail++; $display("FAIL lw_timing: lat %0d rd %0d wr %0d addr %0d required 2 1 0 12", lat, nrd, nwr, ma);
        end
    endtask

    task automatic test_lane_loads();
        logic [31:0] d, ma, exp; logic e; int lat, nrd, nwr; bit ia;
        logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        bit          us [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [4] = '{32'h0D, 32'h0D, 32'h0E, 32'h0E};
        set_word(3, 32'h8070_FF12);
        for (int k = 0; k < 4; k++) begin
            exp = ref_load(sz[k], us[k], ad[k]);
            issue(1'b0, sz[k], us[k], ad[k], 32'h0, 1'b0, d, e, lat, nrd, nwr, ma, ia);
            n_cmp++;
            if (d !== exp || e !== 1'b0 || lat != 2) begin
                n_fail++;
                $display("FAIL lane_load[%0d]: data %h err %0b lat %0d required %h 0 2", k, d, e, lat, exp);
            end
        end
    endtask

    task automatic test_sb_rmw();
        logic [31:0] d, ma; logic e; int lat, nrd, nwr; bit ia;
        set_word(3, 32'h8070_FF12);
        issue(1'b1, 2'd0, 1'b0, 32'h0E, 32'h0000_00AB, 1'b0, d, e, lat, nrd, nwr, ma, ia);
        ref_store(2'd0, 32'h0E, 32'h0000_00AB);
        n_cmp++;
        if (lat != 3 || nrd != 1 || nwr != 1 || e !== 1'b0 || d !== 32'd0) begin
            n_fail++;
            $display("FAIL sb_timing: lat %0d rd %0d wr %0d err %0b data %h required 3 1 1 0 0", lat, nrd, nwr, e, d);
        end
        n_cmp++;
        if (mem[3] !== ref_word(3)) begin
            n_fail++; $display("FAIL sb_mem: word %h required %h", mem[3], ref_word(3));
        end
    endtask

    task automatic test_errors();
        logic [31:0] d, ma; logic e; int lat, nrd, nwr; bit ia; bit xe;
        bit          wr [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz [6] = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
        logic [31:0] ad [6] = '{32'h31, 32'h33, 32'h1000, 32'h40, 32'hFFC, 32'hFFFF_FFFC};
        for (int k = 0; k < 6; k++) begin
            xe = ref_err(sz[k], ad[k]);
            issue(wr[k], sz[k], 1'b0, ad[k], 32'h1234_5678, 1'b0, d, e, lat, nrd, nwr, ma, ia);
            if (wr[k] && !xe) ref_store(sz[k], ad[k], 32'h1234_5678);
            n_cmp++;
            if (e !== xe || lat != exp_lat(wr[k], sz[k], xe) ||
                (xe && (nrd != 0 || nwr != 0 || d !== 32'd0))) begin
                n_fail++;
                $display("FAIL err_case[%0d]: err %0b lat %0d rd %0d wr %0d data %h required err %0b lat %0d",
                         k, e, lat, nrd, nwr, d, xe, exp_lat(wr[k], sz[k], xe));
            end
        end
    endtask

    task automatic test_resp_hold();
        logic [31:0] d0, exp0, exp1; int rd0, wr0; bit ok;
        exp0 = ref_load(2'd2, 1'b0, 32'h1C);
        exp1 = ref_load(2'd0, 1'b1, 32'h21);
        @(negedge Clk);
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqSize = 2'd2;
        bus.ReqUnsigned = 1'b0; bus.ReqAddr = 32'h1C; bus.ReqData = 32'h0; bus.RespReady = 1'b0;
        @(posedge Clk); #1;
        bus.ReqUnsigned = 1'b1; bus.ReqSize = 2'd0; bus.ReqAddr = 32'h21;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.RespValid) begin ok = 1'b1; break; end
            @(posedge Clk); #1;
        end
        n_cmp++;
        if (!ok || bus.RespData !== exp0) begin
            n_fail++; $display("FAIL hold_first: valid %0b data %h required 1 %h", bus.RespValid, bus.RespData, exp0);
        end
        d0 = bus.RespData;
        rd0 = rd_cnt; wr0 = wr_cnt;
        for (int c = 0; c < 4; c++) begin
            @(posedge Clk); #1;
            n_cmp++;
            if (bus.RespValid !== 1'b1 || bus.RespData !== d0 || bus.ReqReady !== 1'b0 ||
                rd_cnt != rd0 || wr_cnt != wr0) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d]: valid %0b data %h ready %0b required 1 %h 0", c,
                         bus.RespValid, bus.RespData, bus.ReqReady, d0);
            end
        end
        bus.RespReady = 1'b1;
        @(posedge Clk); #1;
        bus.RespReady = 1'b0;
        n_cmp++;
        if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: ready %0b valid %0b required 1 0", bus.ReqReady, bus.RespValid);
        end
        @(posedge Clk); #1;
        n_cmp++;
        if (bus.ReqReady !== 1'b0) begin
            n_fail++; $display("FAIL hold_next_accept: ready %0b required 0", bus.ReqReady);
        end
        bus.ReqValid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.RespValid) begin ok = 1'b1; break; end
            @(posedge Clk); #1;
        end
        n_cmp++;
        if (!ok || bus.RespData !== exp1) begin
            n_fail++; $display("FAIL hold_second: valid %0b data %h required 1 %h", bus.RespValid, bus.RespData, exp1);
        end
        bus.RespReady = 1'b1;
        @(posedge Clk); #1;
        bus.RespReady = 1'b0;
    endtask

    task automatic test_reset_mid_wr();
        logic [31:0] old;
        old = ref_word(5);
        @(negedge Clk);
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqSize = 2'd2;
        bus.ReqUnsigned = 1'b0; bus.ReqAddr = 32'h14; bus.ReqData = ~old; bus.RespReady = 1'b0;
        @(posedge Clk); #1;
        bus.ReqValid = 1'b0;
        n_cmp++;
        if (bus.MemWriteEnable !== 1'b1) begin
            n_fail++; $display("FAIL rst_wr_pre: we %0b required 1", bus.MemWriteEnable);
        end
        #1 Reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.MemWriteEnable !== 1'b0 || bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wr_async: we %0b ready %0b valid %0b required 0 1 0",
                     bus.MemWriteEnable, bus.ReqReady, bus.RespValid);
        end
        @(posedge Clk); @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if (mem[5] !== old) begin
            n_fail++; $display("FAIL rst_wr_mem: word %h required %h", mem[5], old);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, ma, addr, data, xd; logic e; int lat, nrd, nwr, idx; bit ia, xe, wr, uns, early;
        logic [1:0] size; logic [1:0] off;
        for (int t = 0; t < 80; t++) begin
            wr    = $urandom_range(0, 1);
            uns   = $urandom_range(0, 1);
            early = $urandom_range(0, 1);
            size  = 2'($urandom_range(0, 3));
            data  = $urandom;
            idx   = $urandom_range(0, 1023);
            off   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) off = off & 2'b10;
                else if (size != 2'd0) off = 2'b00;
            end
            addr = 32'(idx) * 4 + 32'(off);
            case ($urandom_range(0, 9))
                0: addr = 32'h1000 + 32'($urandom_range(0, 15));
                1: addr = 32'hFFFF_FFFC + 32'(off);
                default: ;
            endcase
            xe = ref_err(size, addr);
            xd = (xe || wr) ? 32'd0 : ref_load(size, uns, addr);
            issue(wr, size, uns, addr, data, early, d, e, lat, nrd, nwr, ma, ia);
            if (wr && !xe) ref_store(size, addr, data);
            n_cmp++;
            if (d !== xd || e !== xe || lat != exp_lat(wr, size, xe) || !ia) begin
                n_fail++;
                $display("FAIL rand[%0d]: wr %0b sz %0d a %h data %h err %0b lat %0d idle %0b required %h %0b %0d 1",
                         t, wr, size, addr, d, e, lat, ia, xd, xe, exp_lat(wr, size, xe));
            end
            n_cmp++;
            if (nrd != ((!xe && (!wr || size != 2'd2)) ? 1 : 0) || nwr != ((!xe && wr) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rand_bus[%0d]: rd %0d wr %0d for wr %0b sz %0d err %0b", t, nrd, nwr, wr, size, xe);
            end
            if (wr && !xe) begin
                n_cmp++;
                if (mem[addr[11:2]] !== ref_word(int'(addr[11:2]))) begin
                    n_fail++;
                    $display("FAIL rand_mem[%0d]: word %h required %h", t, mem[addr[11:2]], ref_word(int'(addr[11:2])));
                end
            end
        end
    endtask

    task automatic test_enables_exclusive();
        n_cmp++;
        if (both_seen !== 1'b0) begin
            n_fail++; $display("FAIL enables_exclusive: both strobes seen %0b required 0", both_seen);
        end
    endtask

    initial begin
        bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'd0; bus.ReqUnsigned = 1'b0;
        bus.ReqAddr = 32'd0; bus.ReqData = 32'd0; bus.RespReady = 1'b0;
        for (int i = 0; i < 1024; i++) set_word(i, $urandom);
        test_reset();
        test_sw_lw();
        test_lane_loads();
        test_sb_rmw();
        test_errors();
        test_resp_hold();
        test_reset_mid_wr();
        test_random();
        test_enables_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Initiator side of the data-memory interface. It takes one load/store request at a time from the MEM stage and drives the word-addressed data memory's Addr/DataIn/WriteEnable/ReadEnable pins. It returns sign- or zero-extended load data. Sub-word stores are done as read-modify-write, and misaligned or out-of-range accesses are rejected without touching memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the data memory; valid word index range is 0..DEPTH_WORDS-1.
IDX_WIDTH, 10, width of MemAddr word index actually driven (upper MemAddr bits are zero).

Ports:
Clk  in  1  system clock; all state changes on posedge.
Reset  in  1  asynchronous, active-high reset.
ReqValid  in  1  request present.
ReqReady  out  1  controller can accept a request (IDLE only).
ReqWrite  in  1  1 = store, 0 = load.
ReqSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
ReqUnsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
ReqAddr  in  32  byte address.
ReqData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
RespValid  out  1  response valid; held until RespReady.
RespReady  in  1  consumer accepts response.
RespData  out  32  extended load data; 0 for stores and errors.
RespErr  out  1  misaligned, out-of-range or illegal size.
MemAddr  out  32  word index to memory = ReqAddr[31:2].
MemDataIn  out  32  write data to memory.
MemDataOut  in  32  read data from memory (memory updates it on negedge Clk while read-enabled).
MemWriteEnable  out  1  memory write strobe (memory writes on posedge).
MemReadEnable  out  1  memory read strobe.

Behaviour:
- Byte lanes are little-endian: byte k of a word is bits [8k+7:8k], k = ReqAddr[1:0].
- Reset (async, any state): state=IDLE, ReqReady=1, RespValid=0, RespErr=0, RespData=0, MemAddr=0, MemDataIn=0, MemWriteEnable=0, MemReadEnable=0. A write in progress is aborted, and MemWriteEnable drops immediately, so no write follows reset assertion.
- MemWriteEnable and MemReadEnable are never both 1. Both are 0 outside RD/RMW_RD/WR.
- The request is latched on posedge when ReqValid && ReqReady. Only one request is outstanding.
- Error check at acceptance: error if ReqSize=11, or half with ReqAddr[0]!=0, or word with ReqAddr[1:0]!=0, or ReqAddr[31:2] >= DEPTH_WORDS.
- States:
  - IDLE: ReqReady=1. On accept, go to RESP if error (RespErr=1). SW goes to WR (MemDataIn=ReqData). Any load goes to RD. SB/SH go to RMW_RD.
  - RD: MemReadEnable=1, MemAddr=index. On the next posedge, capture MemDataOut, extract the lane, extend per ReqUnsigned into RespData, then go to RESP.
  - RMW_RD: same bus drive as RD. At posedge, merge the ReqData byte/half into the addressed lane of MemDataOut, leaving other lanes unchanged, into MemDataIn. Then go to WR.
  - WR: MemWriteEnable=1, MemAddr=index, MemDataIn=merged or full word. After one cycle go to RESP.
  - RESP: RespValid=1 with RespData/RespErr stable. On posedge with RespReady, go to IDLE. Otherwise hold.
- Latency from acceptance edge to RespValid:
  - error: 1 cycle
  - LW/LH/LB: 2 cycles
  - SW: 2 cycles
  - SH/SB: 3 cycles
  - RespReady tied high returns to IDLE one cycle later.
- ReqReady is low in every non-IDLE state, and ReqValid is ignored there.
- Word index FF…F or DEPTH_WORDS exactly is an error. DEPTH_WORDS-1 is legal.

Test Plan:
- Reset mid-WR (assert Reset between two posedges while MemWriteEnable=1) -> MemWriteEnable falls asynchronously, state IDLE, memory word at that index keeps its prior value.
- SW ReqAddr=0x30, ReqData=0x0000_0031, then LW 0x30 -> MemAddr=12 both times, write enable exactly 1 cycle, RespData=0x0000_0031, RespErr=0, load RespValid 2 cycles after accept.
- Memory word 3 = 0x8070_FF12: LB 0x0D -> RespData=0xFFFF_FFFF; LBU 0x0D -> 0x0000_00FF; LH 0x0E -> 0xFFFF_8070; LHU 0x0E -> 0x0000_8070.
- SB ReqAddr=0x0E, ReqData=0xAB on word 3 = 0x8070_FF12 -> one read cycle then one write cycle, memory word 3 = 0x80AB_FF12, RespValid 3 cycles after accept.
- LW 0x31, SH 0x33, LW 0x1000 (index 1024), ReqSize=11 -> each gives RespErr=1 one cycle after accept, with no MemReadEnable/MemWriteEnable pulse.
- RespReady held low 4 cycles after a LW -> RespValid/RespData stable for all 4 cycles, ReqReady=0, and a concurrent ReqValid is not accepted until after the RespReady handshake.
